// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Definitions shared by the CPU datapath blocks.
//   - DEFAULT_WIDTH : default datapath width
//   - occ_e         : occupancy encoding of the two-entry skid buffer
// ---------------------------------------------------------------------------
package cpu_defs;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage : cpu_defs

// File: rtl/mux_n.sv
// ---------------------------------------------------------------------------
// mux_n
//   Purely combinational N:1 selector. If sel does not address a channel
//   (possible only when NUM is not a power of two), the output is all-zero.
// Ports
//   in_data  [NUM*WIDTH]  packed channels; channel k = in_data[k*WIDTH +: WIDTH]
//   sel      [SELW]       channel select
//   out_data [WIDTH]      selected channel, or zero when sel >= NUM
// ---------------------------------------------------------------------------
module mux_n
  import cpu_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NUM   = 4
) (
  input  logic [NUM*WIDTH-1:0]     in_data,
  input  logic [$clog2(NUM)-1:0]   sel,
  output logic [WIDTH-1:0]         out_data
);

  localparam int SELW = $clog2(NUM);

  // Channel selection; the zero default covers out-of-range selects.
  always_comb begin
    out_data = {WIDTH{1'b0}};
    for (int k = 0; k < NUM; k++) begin
      if (sel == SELW'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
      end else begin
        out_data = out_data;
      end
    end
  end

endmodule : mux_n

// File: rtl/mux_skid_reg.sv
// ---------------------------------------------------------------------------
// mux_skid_reg
//   N-way W-bit selector whose result is held in a two-entry skid buffer with
//   a valid/ready handshake, a synchronous flush and a registered select tag.
//   The main entry always drives the outputs; the skid entry catches the one
//   word that can arrive while downstream stalls, since in_ready is a
//   registered copy of "skid entry empty" and cannot react within the cycle.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_data    [NUM*WIDTH] packed candidate channels
//   sel        [SELW]      channel select, captured with the data on accept
//   in_valid   upstream offers {in_data, sel}
//   in_ready   block can accept this cycle (registered)
//   flush      synchronous discard of all buffered entries
//   out_data   [WIDTH]     selected data of the head entry
//   out_sel    [SELW]      select value that produced out_data
//   out_valid  head entry valid (registered)
//   out_ready  downstream accepts head this cycle
// ---------------------------------------------------------------------------
module mux_skid_reg
  import cpu_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NUM   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM*WIDTH-1:0]     in_data,
  input  logic [$clog2(NUM)-1:0]   sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(NUM)-1:0]   out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int SELW = $clog2(NUM);

  occ_e              occ_q, occ_d;
  logic [WIDTH-1:0]  main_data_q, main_data_d;
  logic [SELW-1:0]   main_sel_q,  main_sel_d;
  logic [WIDTH-1:0]  skid_data_q, skid_data_d;
  logic [SELW-1:0]   skid_sel_q,  skid_sel_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [WIDTH-1:0]  mux_data;
  logic              accept;
  logic              pop;

  mux_n #(
    .WIDTH (WIDTH),
    .NUM   (NUM)
  ) u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (mux_data)
  );

  assign accept = in_valid  & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  // Occupancy next-state and entry loads; registers hold unless a word moves.
  always_comb begin
    occ_d       = occ_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;

    if (flush) begin
      // Flush wins over everything: any word accepted now is dropped. A pop
      // in this cycle already completed on the bus, so nothing is lost.
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            occ_d       = OCC_ONE;
            main_data_d = mux_data;
            main_sel_d  = sel;
          end else begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            occ_d       = OCC_ONE;
            main_data_d = mux_data;
            main_sel_d  = sel;
          end else if (accept) begin
            occ_d       = OCC_FULL;
            skid_data_d = mux_data;
            skid_sel_d  = sel;
          end else if (pop) begin
            occ_d = OCC_EMPTY;
          end else begin
            occ_d = OCC_ONE;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only the downstream side can move.
          if (pop) begin
            occ_d       = OCC_ONE;
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
          end else begin
            occ_d = OCC_FULL;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end

    // Handshake outputs are registered from the next occupancy.
    in_ready_d  = (occ_d != OCC_FULL);
    out_valid_d = (occ_d != OCC_EMPTY);
  end

  // State and data registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q       <= OCC_EMPTY;
      main_data_q <= {WIDTH{1'b0}};
      main_sel_q  <= {SELW{1'b0}};
      skid_data_q <= {WIDTH{1'b0}};
      skid_sel_q  <= {SELW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;

endmodule : mux_skid_reg

// File: tb/tb_mux_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_skid_reg
//   Directed bench for mux_skid_reg: one NUM=4 instance for the handshake,
//   ordering and flush behaviour, one NUM=3 instance for out-of-range select.
// ---------------------------------------------------------------------------
module tb_mux_skid_reg;

  logic        clk;
  logic        reset;

  // NUM=4 instance
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  // NUM=3 instance
  logic [95:0]  in_data3;
  logic [1:0]   sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_valid3;

  int checks = 0;
  int errors = 0;

  mux_skid_reg #(.WIDTH(32), .NUM(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_skid_reg #(.WIDTH(32), .NUM(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .flush     (1'b0),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
    .out_ready (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = 128'd0;
    sel       = 2'd0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_data3  = 96'd0;
    sel3      = 2'd0;
    in_valid3 = 1'b0;

    // 1. reset then idle
    cyc();
    cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    reset = 1'b0;
    cyc();
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready",  32'(in_ready),  32'd1);

    // 2. single transfer, sel=2 -> channel 2 = 3
    in_data   = {32'h4, 32'h3, 32'h2, 32'h1};
    sel       = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t2_out_data",  out_data,       32'h3);
    chk("t2_out_sel",   32'(out_sel),   32'd2);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    cyc();
    chk("t2_drain_valid", 32'(out_valid), 32'd0);

    // 3. back-pressure: push sel 0,1,3 (values 1,2,4) with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd0;
    cyc();
    chk("t3_one_ready", 32'(in_ready), 32'd1);
    chk("t3_one_data",  out_data,      32'h1);
    sel = 2'd1;
    cyc();
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    chk("t3_full_data",  out_data,      32'h1);
    sel = 2'd3;
    cyc();
    chk("t3_hold_ready", 32'(in_ready),  32'd0);
    chk("t3_hold_data",  out_data,       32'h1);
    chk("t3_hold_sel",   32'(out_sel),   32'd0);
    chk("t3_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cyc();
    chk("t3_rel1_data",  out_data,      32'h2);
    chk("t3_rel1_sel",   32'(out_sel),  32'd1);
    chk("t3_rel1_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("t3_rel2_data",  out_data,       32'h4);
    chk("t3_rel2_sel",   32'(out_sel),   32'd3);
    chk("t3_rel2_valid", 32'(out_valid), 32'd1);
    cyc();
    chk("t3_empty_valid", 32'(out_valid), 32'd0);

    // 4. streaming: one word per cycle, output equals input one cycle later
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = {32'(32'h100 * i + 3), 32'(32'h100 * i + 2),
                 32'(32'h100 * i + 1), 32'(32'h100 * i)};
      sel = 2'(i % 4);
      cyc();
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_data",  out_data,       32'(32'h100 * i + (i % 4)));
      chk("t4_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    cyc();
    chk("t4_drain_valid", 32'(out_valid), 32'd0);

    // 5. NUM=3: sel=3 is out of range -> zero data, raw tag kept
    in_data3  = {32'hC, 32'hB, 32'hA};
    sel3      = 2'd3;
    in_valid3 = 1'b1;
    cyc();
    chk("t5_oor_data",  out_data3,       32'd0);
    chk("t5_oor_sel",   32'(out_sel3),   32'd3);
    chk("t5_oor_valid", 32'(out_valid3), 32'd1);
    sel3 = 2'd1;
    cyc();
    in_valid3 = 1'b0;
    chk("t5_ch1_data", out_data3,     32'hB);
    chk("t5_ch1_sel",  32'(out_sel3), 32'd1);

    // 6. flush while FULL with in_valid high
    in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd0;
    cyc();
    sel = 2'd1;
    cyc();
    chk("t6_full_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    sel   = 2'd2;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t6_flush_valid", 32'(out_valid), 32'd0);
    chk("t6_flush_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    cyc();
    chk("t6_after_valid", 32'(out_valid), 32'd0);
    // flush in ONE while a new word is accepted: the new word is dropped too
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd3;
    cyc();
    chk("t6_one_data", out_data, 32'h44);
    flush = 1'b1;
    sel   = 2'd2;
    cyc();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t6_one_flush_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("t6_one_after_valid", 32'(out_valid), 32'd0);

    // 1b. reset asserted mid-FULL takes effect before the next edge
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd3;
    cyc();
    sel = 2'd2;
    cyc();
    chk("t1b_full_ready", 32'(in_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("t1b_rst_valid", 32'(out_valid), 32'd0);
    chk("t1b_rst_ready", 32'(in_ready),  32'd1);
    chk("t1b_rst_data",  out_data,       32'd0);
    chk("t1b_rst_sel",   32'(out_sel),   32'd0);
    in_valid = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("t1b_post_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_skid_reg
